// File: rtl/cnt_ctrl_arb.sv
// Round-robin arbiter with single-owner locking in front of the one-hot-opcode stopwatch counter.
// One grant per cycle; ack/nack and opcode/valid are registered one cycle after req is sampled.
module cnt_ctrl_arb #(
  parameter int NREQ         = 4,
  parameter int IDW          = 2,
  parameter int HOLD_TIMEOUT = 50000000,
  parameter int TW           = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [3*NREQ-1:0] req_op,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   nack,
  output logic [2:0]        opcode,
  output logic              valid,
  output logic [IDW-1:0]    owner,
  output logic              owned,
  output logic              running
);

  localparam logic [2:0] OP_START = 3'b001;
  localparam logic [2:0] OP_PAUSE = 3'b010;
  localparam logic [2:0] OP_STOP  = 3'b100;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [TW-1:0]  TMAX  = TW'(HOLD_TIMEOUT - 1);
  localparam logic [IDW-1:0] LASTI = IDW'(NREQ - 1);

  logic [1:0]      state_q, state_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREQ-1:0] nack_q, nack_d;
  logic [2:0]      opcode_q, opcode_d;
  logic            valid_q, valid_d;
  logic [IDW-1:0]  owner_q, owner_d;

  logic [NREQ-1:0] elig;
  logic            gnt_vld;
  logic [IDW-1:0]  gnt_id;
  logic [NREQ-1:0] gnt_oh;
  logic [2:0]      gnt_op;
  logic            op_ok;
  logic            own_cmd;
  logic            timeout;

  // A requester whose response is on the outputs this cycle is not eligible again yet.
  always_comb begin
    int best;
    int d;
    best    = NREQ;
    d       = 0;
    elig    = req & ~ack_q & ~nack_q;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    gnt_oh  = '0;
    gnt_op  = '0;
    for (int i = 0; i < NREQ; i++) begin
      d = (i + NREQ - int'(rr_q)) % NREQ;
      if (elig[i] && (d < best)) begin
        best      = d;
        gnt_vld   = 1'b1;
        gnt_id    = IDW'(i);
        gnt_op    = req_op[3*i +: 3];
        gnt_oh    = '0;
        gnt_oh[i] = 1'b1;
      end
    end
  end

  assign op_ok   = (gnt_op == OP_START) || (gnt_op == OP_PAUSE) || (gnt_op == OP_STOP);
  assign own_cmd = gnt_vld && op_ok && (state_q != S_IDLE) && (gnt_id == owner_q);
  assign timeout = (state_q == S_HOLD) && (timer_q == TMAX) && !own_cmd;

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    timer_d  = timer_q;
    ack_d    = '0;
    nack_d   = '0;
    opcode_d = opcode_q;
    valid_d  = 1'b0;
    owner_d  = owner_q;

    if (gnt_vld) begin
      rr_d = (gnt_id == LASTI) ? '0 : gnt_id + IDW'(1);
      if (!op_ok) begin
        nack_d = gnt_oh;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (gnt_op == OP_PAUSE) begin
              nack_d = gnt_oh;
            end else begin
              ack_d    = gnt_oh;
              valid_d  = 1'b1;
              opcode_d = gnt_op;
              if (gnt_op == OP_START) begin
                owner_d = gnt_id;
                state_d = S_RUN;
              end
            end
          end
          S_RUN, S_HOLD: begin
            if (!own_cmd) begin
              nack_d = gnt_oh;
            end else begin
              ack_d = gnt_oh;
              if (gnt_op == OP_STOP) begin
                valid_d  = 1'b1;
                opcode_d = OP_STOP;
                owner_d  = '0;
                state_d  = S_IDLE;
              end else if ((gnt_op == OP_PAUSE) && (state_q == S_RUN)) begin
                valid_d  = 1'b1;
                opcode_d = OP_PAUSE;
                timer_d  = '0;
                state_d  = S_HOLD;
              end else if ((gnt_op == OP_START) && (state_q == S_HOLD)) begin
                valid_d  = 1'b1;
                opcode_d = OP_START;
                state_d  = S_RUN;
              end
            end
          end
          default: begin
            nack_d = gnt_oh;
          end
        endcase
      end
    end

    // An owner command in the timeout cycle takes precedence; anything else lets the hold age.
    if ((state_q == S_HOLD) && !own_cmd) begin
      if (timeout) begin
        valid_d  = 1'b1;
        opcode_d = OP_STOP;
        owner_d  = '0;
        timer_d  = '0;
        state_d  = S_IDLE;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      rr_q     <= '0;
      timer_q  <= '0;
      ack_q    <= '0;
      nack_q   <= '0;
      opcode_q <= '0;
      valid_q  <= 1'b0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      timer_q  <= timer_d;
      ack_q    <= ack_d;
      nack_q   <= nack_d;
      opcode_q <= opcode_d;
      valid_q  <= valid_d;
      owner_q  <= owner_d;
    end
  end

  assign ack     = ack_q;
  assign nack    = nack_q;
  assign opcode  = opcode_q;
  assign valid   = valid_q;
  assign owner   = owner_q;
  assign owned   = (state_q != S_IDLE);
  assign running = (state_q == S_RUN);

endmodule

// File: tb/tb_cnt_ctrl_arb.sv
// Bench for cnt_ctrl_arb: directed scenarios with literal expectations, then random
// multi-requester traffic compared every cycle against a transaction-level model.
module tb_cnt_ctrl_arb;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int HT   = 8;
  localparam int TW   = 4;

  localparam logic [2:0] START = 3'b001;
  localparam logic [2:0] PAUSE = 3'b010;
  localparam logic [2:0] STOP  = 3'b100;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [3*NREQ-1:0] req_op = '0;
  logic [NREQ-1:0]   ack, nack;
  logic [2:0]        opcode;
  logic              valid;
  logic [IDW-1:0]    owner;
  logic              owned, running;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: mode 0 = stopped/unowned, 1 = running, 2 = paused.
  logic [NREQ-1:0] e_ack, e_nack;
  logic [2:0]      e_op;
  logic            e_valid;
  int              e_owner, m_mode, m_rr, m_age;

  always #5 clk = ~clk;

  cnt_ctrl_arb #(.NREQ(NREQ), .IDW(IDW), .HOLD_TIMEOUT(HT), .TW(TW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_op(req_op),
    .ack(ack), .nack(nack), .opcode(opcode), .valid(valid),
    .owner(owner), .owned(owned), .running(running)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [2:0] op);
    return (op == START) || (op == PAUSE) || (op == STOP);
  endfunction

  task automatic model_reset();
    e_ack = '0; e_nack = '0; e_op = '0; e_valid = 1'b0;
    e_owner = 0; m_mode = 0; m_rr = 0; m_age = 0;
  endtask

  task automatic strobe(input logic [2:0] op);
    e_valid = 1'b1;
    e_op    = op;
  endtask

  task automatic model_step();
    int g, prev, idx;
    logic [NREQ-1:0] pend;
    logic [2:0] op;
    bit mine;
    if (!rst) begin
      model_reset();
      return;
    end
    pend = req & ~e_ack & ~e_nack;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (m_rr + k) % NREQ;
      if (g < 0 && pend[idx]) g = idx;
    end
    prev = m_mode;
    e_ack = '0; e_nack = '0; e_valid = 1'b0;
    mine = 1'b0;
    if (g >= 0) begin
      m_rr = (g + 1) % NREQ;
      op   = req_op[3*g +: 3];
      mine = (prev != 0) && (g == e_owner) && legal(op);
      if (!legal(op) || (prev != 0 && !mine) || (prev == 0 && op == PAUSE)) begin
        e_nack[g] = 1'b1;
      end else begin
        e_ack[g] = 1'b1;
        if (op == STOP) begin
          strobe(STOP); m_mode = 0; e_owner = 0;
        end else if (op == START) begin
          if (prev != 1) strobe(START);
          if (prev == 0) e_owner = g;
          m_mode = 1;
        end else if (prev == 1) begin
          strobe(PAUSE); m_age = 0; m_mode = 2;
        end
      end
    end
    if (prev == 2 && !mine) begin
      if (m_age == HT - 1) begin
        strobe(STOP); m_mode = 0; e_owner = 0;
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic compare();
    chk("ack", ack, e_ack);
    chk("nack", nack, e_nack);
    chk("valid", valid, e_valid);
    chk("opcode", opcode, e_op);
    chk("owner", owner, e_owner);
    chk("owned", owned, m_mode != 0);
    chk("running", running, m_mode == 1);
  endtask

  // Advance one clock: model follows the DUT's edge, outputs are checked at the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic set_req(input int i, input logic [2:0] op);
    req[i] = 1'b1;
    req_op[3*i +: 3] = op;
  endtask

  initial begin
    logic [2:0] op;
    int r, busy;
    model_reset();
    cyc(); cyc();
    chk("rst_ack", ack, 0);
    chk("rst_valid", valid, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_owned", owned, 0);
    rst = 1'b1;

    // Scenario 1: first START takes ownership
    set_req(1, START);
    cyc();
    chk("t1_ack", ack, 4'b0010);
    chk("t1_valid", valid, 1);
    chk("t1_opcode", opcode, START);
    chk("t1_owner", owner, 1);
    chk("t1_running", running, 1);
    req[1] = 1'b0;

    // Scenario 2: foreign STOP refused, owner PAUSE accepted
    set_req(2, STOP);
    cyc();
    chk("t2_nack", nack, 4'b0100);
    chk("t2_valid", valid, 0);
    req[2] = 1'b0;
    set_req(1, PAUSE);
    cyc();
    chk("t2_ack", ack, 4'b0010);
    chk("t2_opcode", opcode, PAUSE);
    chk("t2_hold", {owned, running}, 2'b10);
    req[1] = 1'b0;

    // Scenario 3: paused run auto-stops HT cycles after the PAUSE strobe
    repeat (HT - 1) begin
      cyc();
      chk("t3_quiet", valid, 0);
    end
    cyc();
    chk("t3_valid", valid, 1);
    chk("t3_opcode", opcode, STOP);
    chk("t3_owned", owned, 0);
    chk("t3_owner", owner, 0);

    // Scenario 4: simultaneous STARTs from reset, round-robin order
    rst = 1'b0;
    model_reset();
    cyc();
    rst = 1'b1;
    set_req(0, START); set_req(1, START); set_req(3, START);
    cyc();
    chk("t4_ack0", ack, 4'b0001);
    chk("t4_owner", owner, 0);
    chk("t4_running", running, 1);
    req[0] = 1'b0;
    cyc();
    chk("t4_nack1", nack, 4'b0010);
    req[1] = 1'b0;
    cyc();
    chk("t4_nack3", nack, 4'b1000);
    req[3] = 1'b0;
    set_req(2, START); set_req(3, START);
    cyc();
    chk("t4_rr0", nack, 4'b0100);
    req[2] = 1'b0;
    cyc();
    chk("t4_nack3b", nack, 4'b1000);
    req[3] = 1'b0;

    // Scenario 5: owner START lands on the timeout cycle
    set_req(0, PAUSE);
    cyc();
    chk("t5_pause", opcode, PAUSE);
    req[0] = 1'b0;
    repeat (HT - 1) cyc();
    set_req(0, START);
    cyc();
    chk("t5_ack", ack, 4'b0001);
    chk("t5_opcode", opcode, START);
    chk("t5_running", running, 1);
    req[0] = 1'b0;
    repeat (HT + 2) cyc();
    chk("t5_still_run", running, 1);

    // Scenario 6: illegal opcode, IDLE PAUSE/STOP, asynchronous reset mid-run
    set_req(2, 3'b011);
    cyc();
    chk("t6_bad_nack", nack, 4'b0100);
    chk("t6_bad_valid", valid, 0);
    req[2] = 1'b0;
    set_req(0, STOP);
    cyc();
    req[0] = 1'b0;
    set_req(3, PAUSE);
    cyc();
    chk("t6_idle_pause", nack, 4'b1000);
    req[3] = 1'b0;
    cyc();
    set_req(3, STOP);
    cyc();
    chk("t6_idle_stop", {ack, valid, opcode}, {4'b1000, 1'b1, STOP});
    req[3] = 1'b0;
    set_req(1, START);
    cyc();
    req[1] = 1'b0;
    cyc();
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("t6_arst", {ack, nack, opcode, valid, owner, owned, running}, 0);
    cyc();
    rst = 1'b1;

    // Random traffic with alternating busy and quiet phases
    busy = 1;
    for (int c = 0; c < 4000; c++) begin
      if (c % 150 == 0) busy = !busy;
      cyc();
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && (ack[i] || nack[i])) begin
          req[i] = 1'b0;
        end else if (req[i]) begin
          if ($urandom_range(0, 31) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, busy ? 3 : 20) == 0) begin
          r = $urandom_range(0, 9);
          if (r < 4)      op = START;
          else if (r < 6) op = PAUSE;
          else if (r < 9) op = STOP;
          else begin
            op = 3'($urandom_range(0, 7));
            if (legal(op)) op = 3'b110;
          end
          set_req(i, op);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
